// File: rtl/player_anim_controller.sv
// Player sprite animation FSM with frame sequencing and sprite-ROM address generation.
// Defining ANIM_DEATH_EN enables the hit -> DEAD death sequence; otherwise hit is ignored.
module player_anim_controller #(
    parameter int unsigned FRAME_DIV   = 4,
    parameter logic [20:0] LEFT_OFFSET = 21'd50620
) (
    input  logic        frame_Clk,
    input  logic        Reset,
    input  logic [3:0]  keycode,
    input  logic        moving,
    input  logic        playerDirection,
    input  logic        onGround,
    input  logic        hit,
    output logic [2:0]  animState,
    output logic [2:0]  frameIndex,
    output logic [20:0] frameBase,
    output logic [9:0]  PlayerWidth,
    output logic [9:0]  PlayerHeight,
    output logic        deathDone
);
    localparam int unsigned DIV_W  = 4;
    localparam int unsigned ADDR_W = 21;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = 21'd2312;

`ifdef ANIM_DEATH_EN
    localparam bit DEATH_EN = 1'b1;
`else
    localparam bit DEATH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        DOWN = 3'd2,
        JUMP = 3'd3,
        DEAD = 3'd4
    } state_t;

    state_t            state;
    state_t            nextState;
    state_t            groundState;
    logic [DIV_W-1:0]  divCnt;
    logic              dirReg;
    logic              jumpHold;
    logic              deathReg;
    logic              hitEff;
    logic              jumpKey;
    logic              downKey;
    logic [ADDR_W-1:0] stateBase;

    assign hitEff  = DEATH_EN && hit;
    assign jumpKey = (keycode == 4'h1) && onGround;
    assign downKey = (keycode == 4'h3) && onGround;

    // State chosen when no jump is being started or continued.
    assign groundState = downKey ? DOWN : (moving ? RUN : IDLE);

    function automatic logic [2:0] frameCount(input state_t s);
        case (s)
            RUN:     frameCount = 3'd6;
            JUMP:    frameCount = 3'd2;
            DEAD:    frameCount = 3'd3;
            default: frameCount = 3'd1;
        endcase
    endfunction

    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE, RUN, DOWN: nextState = hitEff ? DEAD : (jumpKey ? JUMP : groundState);
            JUMP: begin
                if (hitEff)                     nextState = DEAD;
                else if (!jumpHold && onGround) nextState = groundState;
                else                            nextState = JUMP;
            end
            DEAD:    nextState = DEATH_EN ? DEAD : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // jumpHold blocks landing on the first edge after a jump starts.
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            state      <= IDLE;
            divCnt     <= '0;
            frameIndex <= '0;
            dirReg     <= 1'b0;
            jumpHold   <= 1'b0;
            deathReg   <= 1'b0;
        end else begin
            state    <= nextState;
            jumpHold <= (nextState == JUMP) && (state != JUMP);
            if (state != DEAD) dirReg <= playerDirection;

            if (nextState != state) begin
                divCnt     <= '0;
                frameIndex <= '0;
            end else if (divCnt == DIV_LAST) begin
                divCnt <= '0;
                if (state == DEAD) begin
                    if (frameIndex == 3'd2) deathReg   <= 1'b1;
                    else                    frameIndex <= frameIndex + 3'd1;
                end else if (frameIndex + 3'd1 >= frameCount(state)) begin
                    frameIndex <= '0;
                end else begin
                    frameIndex <= frameIndex + 3'd1;
                end
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        stateBase = '0;
        case (state)
            RUN:     stateBase = 21'd2312;
            JUMP:    stateBase = 21'd16184;
            DOWN:    stateBase = 21'd21680;
            DEAD:    stateBase = 21'd24000;
            default: stateBase = '0;
        endcase
    end

    assign animState    = state;
    assign frameBase    = stateBase + ADDR_W'(frameIndex) * FRAME_SIZE
                        + (dirReg ? LEFT_OFFSET : ADDR_W'(0));
    assign PlayerWidth  = (state == DOWN) ? 10'd68 : 10'd34;
    assign PlayerHeight = (state == DOWN) ? 10'd34 : 10'd68;
    assign deathDone    = DEATH_EN && deathReg;

endmodule

// File: tb/tb_player_anim_controller.sv
// Randomized self-checking bench for player_anim_controller against a time-in-state reference model.
module tb_player_anim_controller;
    localparam int DIV   = 4;
    localparam int LEFT  = 50620;
    localparam int FSIZE = 2312;
    localparam int S_IDLE = 0, S_RUN = 1, S_DOWN = 2, S_JUMP = 3, S_DEAD = 4;

`ifdef ANIM_DEATH_EN
    localparam bit DEATH_EN = 1'b1;
`else
    localparam bit DEATH_EN = 1'b0;
`endif

    logic        frame_Clk = 1'b0;
    logic        Reset;
    logic [3:0]  keycode;
    logic        moving;
    logic        playerDirection;
    logic        onGround;
    logic        hit;
    logic [2:0]  animState;
    logic [2:0]  frameIndex;
    logic [20:0] frameBase;
    logic [9:0]  PlayerWidth;
    logic [9:0]  PlayerHeight;
    logic        deathDone;

    player_anim_controller dut (
        .frame_Clk(frame_Clk), .Reset(Reset), .keycode(keycode), .moving(moving),
        .playerDirection(playerDirection), .onGround(onGround), .hit(hit),
        .animState(animState), .frameIndex(frameIndex), .frameBase(frameBase),
        .PlayerWidth(PlayerWidth), .PlayerHeight(PlayerHeight), .deathDone(deathDone)
    );

    always #5 frame_Clk = ~frame_Clk;

    int nVec = 0;
    int nErr = 0;

    // Model: current state plus number of edges spent in it since entry.
    int mState = 0;
    int mCyc   = 0;
    bit mDir   = 1'b0;
    int FRAMES[5] = '{1, 6, 1, 2, 3};
    int BASES[5]  = '{0, 2312, 21680, 16184, 24000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelEdge();
        int ground;
        int nxt;
        if (Reset) begin
            mState = S_IDLE;
            mCyc   = 0;
            mDir   = 1'b0;
        end else begin
            if (mState != S_DEAD) mDir = playerDirection;
            ground = (keycode == 4'h3 && onGround) ? S_DOWN : (moving ? S_RUN : S_IDLE);
            if (mState == S_DEAD)         nxt = S_DEAD;
            else if (DEATH_EN && hit)     nxt = S_DEAD;
            else if (mState == S_JUMP)    nxt = (mCyc >= 1 && onGround) ? ground : S_JUMP;
            else                          nxt = (keycode == 4'h1 && onGround) ? S_JUMP : ground;
            if (nxt == mState) mCyc++;
            else begin
                mState = nxt;
                mCyc   = 0;
            end
        end
    endtask

    task automatic checkOutputs();
        int steps;
        int eFrame;
        int eBase;
        steps = mCyc / DIV;
        if (mState == S_DEAD) eFrame = (steps > 2) ? 2 : steps;
        else                  eFrame = steps % FRAMES[mState];
        eBase = BASES[mState] + eFrame * FSIZE + (mDir ? LEFT : 0);
        check("animState",    32'(animState),    32'(mState));
        check("frameIndex",   32'(frameIndex),   32'(eFrame));
        check("frameBase",    32'(frameBase),    32'(eBase));
        check("PlayerWidth",  32'(PlayerWidth),  (mState == S_DOWN) ? 32'd68 : 32'd34);
        check("PlayerHeight", 32'(PlayerHeight), (mState == S_DOWN) ? 32'd34 : 32'd68);
        check("deathDone",    32'(deathDone),    32'(mState == S_DEAD && mCyc >= 3 * DIV));
    endtask

    task automatic tick();
        @(posedge frame_Clk);
        modelEdge();
        #1;
        checkOutputs();
    endtask

    task automatic setIn(input logic [3:0] kc, input logic mv, input logic dir,
                         input logic og, input logic ht);
        keycode = kc; moving = mv; playerDirection = dir; onGround = og; hit = ht;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        setIn(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        doReset();
        check("reset_base", 32'(frameBase), 32'd0);

        // Run cycle: six frames every DIV edges, then wrap.
        setIn(4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) tick();

        // Crouch facing left.
        setIn(4'h3, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("down_base",   32'(frameBase),    32'd72300);
        check("down_width",  32'(PlayerWidth),  32'd68);
        check("down_height", 32'(PlayerHeight), 32'd34);

        // Jump, airborne, land with no movement.
        doReset();
        setIn(4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        setIn(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        setIn(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("land_idle", 32'(animState), 32'd0);

        // Jump with ground held: first edge after entry may not land.
        setIn(4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        setIn(4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("jump_hold", 32'(animState), 32'd3);
        tick();

`ifdef ANIM_DEATH_EN
        doReset();
        setIn(4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) tick();
        setIn(4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check("dead_entry_base", 32'(frameBase), 32'd24000);
        setIn(4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        check("dead_done",  32'(deathDone), 32'd1);
        check("dead_base2", 32'(frameBase), 32'd28624);
        for (int i = 0; i < 10; i++) begin
            setIn(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        setIn(4'h1, 1'b1, 1'b1, 1'b1, 1'b1);
        doReset();
        check("dead_reset_base", 32'(frameBase), 32'd0);
        check("dead_reset_done", 32'(deathDone), 32'd0);
`else
        doReset();
        setIn(4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        setIn(4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check("hit_ignored_state", 32'(animState), 32'd1);
        check("hit_ignored_done",  32'(deathDone), 32'd0);
`endif

        // Randomized traffic with occasional hits and resets.
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = $urandom_range(0, 3);
            case (k)
                0:       keycode = 4'h1;
                1:       keycode = 4'h3;
                2:       keycode = 4'h0;
                default: keycode = 4'($urandom_range(0, 15));
            endcase
            moving          = 1'($urandom);
            playerDirection = 1'($urandom);
            onGround        = ($urandom_range(0, 9) < 7);
            hit             = ($urandom_range(0, 39) == 0);
            Reset           = ($urandom_range(0, 99) == 0);
            tick();
        end
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
